scan_decoder: RTL
=================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 2: address width; legal range 1..6.
REQ-002 The block SHALL have parameter DWELL, default 4: cycles each scan position is held; legal range 1..255, used only when SCAN_DECODER_DWELL_EN is defined.
REQ-003 The block SHALL derive local parameter OUT_N = 2**ADDR_W: the number of one-hot outputs.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 The block SHALL have port enable, input, 1 bit: 0 forces all outputs low.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = direct decode, 1 = scan.
REQ-008 The block SHALL have port load, input, 1 bit: scan mode only; loads address into the scan position.
REQ-009 The block SHALL have port address, input, ADDR_W bits: decode or load value.
REQ-010 The block SHALL have port out, output, OUT_N bits: registered one-hot or all-zero output.
REQ-011 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse on scan wrap-around.

Function
REQ-012 Internal state SHALL be the position register pos (ADDR_W bits), the dwell counter dcnt (8 bits), out and wrap.
REQ-013 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-014 The rising edge of clk SHALL be the only update point.
REQ-015 Direct mode (mode=0, enable=1): out SHALL equal 1<<address one cycle after address is sampled (latency 1).
REQ-016 Direct mode SHALL leave pos unchanged, clear dcnt and hold wrap at 0.
REQ-017 When enable=0 in either mode: out SHALL be 0 next cycle, wrap 0, dcnt 0 and pos held.
REQ-018 In scan mode (mode=1, enable=1), priority SHALL be: load first, then start-from-idle, then advance.
REQ-019 Scan load=1: pos SHALL take address, out SHALL take 1<<address, dcnt SHALL clear and wrap SHALL be 0.
REQ-020 Scan start-from-idle (out==0 before the edge, load=0): pos SHALL be held, out SHALL take 1<<pos and dcnt SHALL clear.
REQ-021 Scan advance (out!=0, load=0): when the advance condition of REQ-029/REQ-030 holds, pos SHALL take (pos+1) mod OUT_N, out SHALL take 1<<(new pos) and dcnt SHALL clear.
REQ-022 On a scan edge where the advance condition does not hold, dcnt SHALL increment and out and pos SHALL be held.
REQ-023 wrap SHALL be 1 for exactly one cycle, in the cycle where out becomes bit 0 because an advance from pos=OUT_N-1 occurred.
REQ-024 A load of address 0 SHALL NOT assert wrap.
REQ-025 A mode change 1->0 SHALL freeze pos.
REQ-026 A mode change 0->1 while out!=0 SHALL continue as an advance from the frozen pos (not from address), with dcnt starting at 0.
REQ-027 Every output cycle, out SHALL have at most one bit set.

Reset
REQ-028 reset_n=0 at a rising edge SHALL set out=0, wrap=0, pos=0 and dcnt=0, overriding all other inputs, including mid-scan and mid-dwell.

Configuration
REQ-029 With macro SCAN_DECODER_DWELL_EN defined, the advance condition SHALL be dcnt==DWELL-1, so each position is held DWELL cycles.
REQ-030 Without SCAN_DECODER_DWELL_EN, the advance condition SHALL always be true: advance every enabled scan cycle, DWELL ignored and dcnt constant 0.

Verification
REQ-031 Reset scenario: ADDR_W=2; reset_n=0 for 2 cycles with enable=1, mode=1 -> out=0000, wrap=0; first edge after release -> out=0001.
REQ-032 Direct decode scenario: ADDR_W=3, mode=0, enable=1, address=5 -> out=00100000 one cycle later; enable=0 -> out=0 next cycle.
REQ-033 Scan without macro scenario: ADDR_W=2, load address=2 then load=0 -> out sequence 0100, 1000, 0001 (wrap=1 this cycle only), 0010.
REQ-034 Scan with macro scenario: DWELL=3, ADDR_W=2, from idle -> 0001 x3 cycles, 0010 x3 cycles; load address=3 mid-dwell -> 1000 next cycle with a fresh 3-cycle dwell.
REQ-035 Reset mid-operation scenario: reset_n=0 at pos=3 mid-dwell -> out=0, pos=0 next cycle; after release, scan restarts at 0001 with wrap=0.

Source files
------------

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a direct-decode mode and a scanning mode.
// Define SCAN_DECODER_DWELL_EN to hold each scan position for DWELL cycles.
module scan_decoder #(
   parameter  int ADDR_W = 2,
   parameter  int DWELL  = 4,
   localparam int OUT_N  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              mode,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [OUT_N-1:0]  out,
   output logic              wrap
);

   logic [ADDR_W-1:0] r_pos;
   logic [7:0]        r_dcnt;
   logic [OUT_N-1:0]  r_out;
   logic              r_wrap;

   logic [ADDR_W-1:0] w_pos_nxt;
   logic [7:0]        w_dcnt_nxt;
   logic [OUT_N-1:0]  w_out_nxt;
   logic              w_wrap_nxt;
   logic [ADDR_W-1:0] w_pos_inc;
   logic              w_adv;

   function automatic logic [OUT_N-1:0] f_onehot(input logic [ADDR_W-1:0] a);
      f_onehot = OUT_N'(1'b1) << a;
   endfunction

   assign w_pos_inc = r_pos + ADDR_W'(1'b1);

`ifdef SCAN_DECODER_DWELL_EN
   // dcnt counts completed cycles at the current position; advance on the last one
   assign w_adv = (r_dcnt == 8'(DWELL - 1));
`else
   logic [7:0] w_unused_dwell;
   assign w_unused_dwell = 8'(DWELL);
   assign w_adv          = 1'b1;
`endif

   // Next-state selection: disable, direct decode, then scan load/start/advance/dwell
   always_comb begin
      w_pos_nxt  = r_pos;
      w_dcnt_nxt = 8'd0;
      w_out_nxt  = '0;
      w_wrap_nxt = 1'b0;
      if (!enable) begin
         w_out_nxt = '0;
      end else if (!mode) begin
         w_out_nxt = f_onehot(address);
      end else if (load) begin
         w_pos_nxt = address;
         w_out_nxt = f_onehot(address);
      end else if (r_out == '0) begin
         w_out_nxt = f_onehot(r_pos);
      end else if (w_adv) begin
         w_pos_nxt  = w_pos_inc;
         w_out_nxt  = f_onehot(w_pos_inc);
         w_wrap_nxt = (r_pos == {ADDR_W{1'b1}});
      end else begin
         w_dcnt_nxt = r_dcnt + 8'd1;
         w_out_nxt  = r_out;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pos  <= '0;
         r_dcnt <= 8'd0;
         r_out  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_pos  <= w_pos_nxt;
         r_dcnt <= w_dcnt_nxt;
         r_out  <= w_out_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign out  = r_out;
   assign wrap = r_wrap;

endmodule
